// File: rtl/dcache_arb_pkg.sv
// dcache_arb_pkg: shared types and helpers for the dcache request-port arbiter.
// Ports: none (package). Holds the FSM state enum, the hold-register layout,
//        the round-robin selection result type and the rr_select() function.
// Struct fields are sized for the largest supported configuration
// (8 ports, 64-bit address/data, up to 16 TIDs); narrower builds zero-extend.
package dcache_arb_pkg;

  localparam int unsigned MAX_PORTS   = 8;
  localparam int unsigned PORT_W      = 3;
  localparam int unsigned MAX_ADDR_W  = 64;
  localparam int unsigned MAX_DATA_W  = 64;
  localparam int unsigned MAX_BE_W    = MAX_DATA_W / 8;
  localparam int unsigned MAX_TID_W   = 4;
  localparam int unsigned STALL_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Request captured at accept time and replayed on the mem_* port until granted.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic                  we;
    logic [MAX_DATA_W-1:0] wdata;
    logic [MAX_BE_W-1:0]   be;
    logic [PORT_W-1:0]     port;
    logic [MAX_TID_W-1:0]  tid;
  } hold_req_t;

  typedef struct packed {
    logic              found;
    logic [PORT_W-1:0] idx;
  } rr_sel_t;

  // First set bit of valid[0..n-1] at or after ptr, wrapping at n.
  // ptr is always < n, so ptr+i stays below 2n and one subtraction wraps it.
  function automatic rr_sel_t rr_select(input logic [MAX_PORTS-1:0] valid,
                                        input logic [PORT_W-1:0]    ptr,
                                        input int unsigned          n);
    rr_sel_t     r;
    int unsigned p;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (i < n && !r.found) begin
        p = 32'(ptr) + i;
        if (p >= n) p = p - n;
        if (valid[p[PORT_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = p[PORT_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_tid_pool.sv
// tid_pool: transaction-ID free bitmap plus TID->port return table.
// Latency: lowest-free and lookup are combinational; allocate/free take effect at the next edge.
// Backpressure: none; any_free=0 tells the arbiter to stop accepting.
// Ports: clk/rst_n (sync, active-low); alloc_en/alloc_tid/alloc_port mark a TID busy and
//        record its owner; free_en/free_tid release a TID (ignored if already free);
//        any_free/low_free/any_busy report pool state; free_hit/free_port give the owner
//        of a valid release in the same cycle.
// Optional check: define MEM_ARB_ASSERT_EN to assert on releases of a free TID.
module tid_pool
  import dcache_arb_pkg::*;
#(
  parameter int unsigned TID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [TID_W-1:0]  alloc_tid,
  input  logic [PORT_W-1:0] alloc_port,
  input  logic              free_en,
  input  logic [TID_W-1:0]  free_tid,
  output logic              any_free,
  output logic [TID_W-1:0]  low_free,
  output logic              any_busy,
  output logic              free_hit,
  output logic [PORT_W-1:0] free_port
);

  localparam int unsigned NTID = 1 << TID_W;

  logic [NTID-1:0]   busy;
  logic [PORT_W-1:0] port_tab [NTID];

  assign any_free  = ~&busy;
  assign any_busy  = |busy;
  assign free_hit  = free_en && busy[free_tid];
  assign free_port = port_tab[free_tid];

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    low_free = '0;
    for (int i = NTID - 1; i >= 0; i--) begin
      if (!busy[i]) low_free = TID_W'(i);
    end
  end

  // The TID being allocated was free when it was captured and cannot be freed
  // before its grant, so alloc and free never target the same entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < NTID; i++) port_tab[i] <= '0;
    end else begin
      if (free_hit) busy[free_tid] <= 1'b0;
      if (alloc_en) begin
        busy[alloc_tid]     <= 1'b1;
        port_tab[alloc_tid] <= alloc_port;
      end
    end
  end

`ifdef MEM_ARB_ASSERT_EN
  always @(posedge clk) begin
    if (free_en) assert (busy[free_tid]);
  end
`endif

endmodule

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: round-robin share of one dcache request port with TID tagging.
// Latency: requester accept -> mem_req_o 1 cycle; response routed to its port same cycle.
// Backpressure: ready withheld while holding a request or while no TID is free.
// Ports: clk_i, rst_ni (sync, active-low); req_* per-port flattened requests with
//        req_ready_o one-hot accept; rsp_valid_o one-hot response strobe with shared
//        rsp_rdata_o; mem_* downstream req/gnt channel carrying mem_tid_o; mem_rvalid_i,
//        mem_rtid_i, mem_rdata_i unstallable responses; busy_o while anything is in flight.
// Optional: define DCACHE_ARB_PERF_EN to add stall_cnt_o (16-bit saturating per-port
//           counts of cycles with valid set and ready low).
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NR_PORTS = 3,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned TID_W    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NR_PORTS-1:0]          req_valid_i,
  output logic [NR_PORTS-1:0]          req_ready_o,
  input  logic [NR_PORTS*ADDR_W-1:0]   req_addr_i,
  input  logic [NR_PORTS-1:0]          req_we_i,
  input  logic [NR_PORTS*DATA_W-1:0]   req_wdata_i,
  input  logic [NR_PORTS*DATA_W/8-1:0] req_be_i,
  output logic [NR_PORTS-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]            rsp_rdata_o,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic                         mem_we_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  output logic [DATA_W/8-1:0]          mem_be_o,
  output logic [TID_W-1:0]             mem_tid_o,
  input  logic                         mem_rvalid_i,
  input  logic [TID_W-1:0]             mem_rtid_i,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  output logic                         busy_o
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [NR_PORTS*STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e        state;
  logic [PORT_W-1:0] rr_ptr;
  hold_req_t         hold;
  rr_sel_t           sel;

  logic              accept;
  logic              grant;
  logic              any_free;
  logic [TID_W-1:0]  low_free;
  logic              tid_any_busy;
  logic              rsp_hit;
  logic [PORT_W-1:0] rsp_port;

  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  // --------------------------------------------------------------------------
  // Arbitration: only in IDLE, and only when a TID can be handed out.
  // --------------------------------------------------------------------------
  assign sel    = rr_select(MAX_PORTS'(req_valid_i), rr_ptr, NR_PORTS);
  assign accept = rst_ni && (state == IDLE) && sel.found && any_free;
  assign grant  = (state == HOLD) && mem_gnt_i;

  // Ready decode and request mux share the selected index; constant slices per port.
  always_comb begin
    req_ready_o = '0;
    cap_addr    = '0;
    cap_we      = 1'b0;
    cap_wdata   = '0;
    cap_be      = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (sel.idx == PORT_W'(p)) begin
        req_ready_o[p] = accept;
        cap_addr       = req_addr_i[p*ADDR_W +: ADDR_W];
        cap_we         = req_we_i[p];
        cap_wdata      = req_wdata_i[p*DATA_W +: DATA_W];
        cap_be         = req_be_i[p*BE_W +: BE_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM with hold register. The round-robin pointer only moves on grant, so a
  // port that was accepted but not yet granted keeps its place.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      rr_ptr <= '0;
      hold   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold.addr  <= MAX_ADDR_W'(cap_addr);
            hold.we    <= cap_we;
            hold.wdata <= MAX_DATA_W'(cap_wdata);
            hold.be    <= MAX_BE_W'(cap_be);
            hold.port  <= sel.idx;
            hold.tid   <= MAX_TID_W'(low_free);
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (mem_gnt_i) begin
            state  <= IDLE;
            rr_ptr <= (hold.port == PORT_W'(NR_PORTS - 1)) ? '0 : hold.port + PORT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Downstream request straight from the hold register: stable until granted.
  assign mem_req_o   = (state == HOLD);
  assign mem_addr_o  = hold.addr[ADDR_W-1:0];
  assign mem_we_o    = hold.we;
  assign mem_wdata_o = hold.wdata[DATA_W-1:0];
  assign mem_be_o    = hold.be[BE_W-1:0];
  assign mem_tid_o   = hold.tid[TID_W-1:0];

  // Fields are sized for the widest build; upper bits are zero in narrower ones.
  logic hold_unused;
  assign hold_unused = ^hold;

  // --------------------------------------------------------------------------
  // TID pool and response routing.
  // --------------------------------------------------------------------------
  tid_pool #(
    .TID_W (TID_W)
  ) u_tid_pool (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .alloc_en   (grant),
    .alloc_tid  (hold.tid[TID_W-1:0]),
    .alloc_port (hold.port),
    .free_en    (mem_rvalid_i && rst_ni),
    .free_tid   (mem_rtid_i),
    .any_free   (any_free),
    .low_free   (low_free),
    .any_busy   (tid_any_busy),
    .free_hit   (rsp_hit),
    .free_port  (rsp_port)
  );

  // Responses on a free TID (stale after reset, or bogus) give no strobe.
  always_comb begin
    rsp_valid_o = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      rsp_valid_o[p] = rsp_hit && (rsp_port == PORT_W'(p));
    end
  end

  assign rsp_rdata_o = rsp_hit ? mem_rdata_i : '0;
  assign busy_o      = (state == HOLD) || tid_any_busy;

`ifdef DCACHE_ARB_PERF_EN
  // --------------------------------------------------------------------------
  // Per-port stall counters: cycles spent waiting with valid high.
  // --------------------------------------------------------------------------
  logic [STALL_CNT_W-1:0] stall_cnt [NR_PORTS];

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_PORTS; p++) begin
      if (!rst_ni) begin
        stall_cnt[p] <= '0;
      end else if (req_valid_i[p] && !req_ready_o[p] && (stall_cnt[p] != '1)) begin
        stall_cnt[p] <= stall_cnt[p] + STALL_CNT_W'(1);
      end
    end
  end

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_stall_out
    assign stall_cnt_o[p*STALL_CNT_W +: STALL_CNT_W] = stall_cnt[p];
  end
`endif

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single write-through data-cache request port among NR_PORTS requesters: load unit, vector load/store unit, PTW.
- Round-robin arbitration; the downstream request is held stable until granted.
- Each accepted request is tagged with a free transaction ID from a 2**TID_W pool.
- Out-of-order responses are routed back to the issuing port by TID lookup.
- Sits between the requesters and the dcache memory-side request interface.

Parameters:
- NR_PORTS, 3, number of requesters (2..8).
- ADDR_W, 64, request address width.
- DATA_W, 64, data width; byte-enable width is DATA_W/8.
- TID_W, 2, transaction-ID width; the pool holds 2**TID_W IDs, which is also the outstanding limit.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  NR_PORTS  per-port request valid.
- req_ready_o  out  NR_PORTS  per-port request accepted (one-hot or zero).
- req_addr_i  in  NR_PORTS*ADDR_W  per-port address.
- req_we_i  in  NR_PORTS  per-port write enable.
- req_wdata_i  in  NR_PORTS*DATA_W  per-port write data.
- req_be_i  in  NR_PORTS*DATA_W/8  per-port byte enables.
- rsp_valid_o  out  NR_PORTS  per-port response strobe (one-hot or zero).
- rsp_rdata_o  out  DATA_W  response data, shared by all ports.
- mem_req_o  out  1  downstream request valid.
- mem_gnt_i  in  1  downstream grant.
- mem_addr_o  out  ADDR_W  downstream address.
- mem_we_o  out  1  downstream write enable.
- mem_wdata_o  out  DATA_W  downstream write data.
- mem_be_o  out  DATA_W/8  downstream byte enables.
- mem_tid_o  out  TID_W  transaction ID of the downstream request.
- mem_rvalid_i  in  1  response valid; cannot be backpressured.
- mem_rtid_i  in  TID_W  ID of the returning transaction.
- mem_rdata_i  in  DATA_W  response data.
- busy_o  out  1  at least one transaction outstanding or in flight.

Behaviour:
- Reset: all synchronous, applied when rst_ni=0 at a clock edge.
  - All outputs reset to 0.
  - FSM goes to IDLE, round-robin pointer to 0, TID pool all free, TID table cleared.
  - Reset mid-operation discards all outstanding transactions; responses arriving later are ignored.
- FSM states IDLE and HOLD.
- IDLE:
  - If any req_valid_i is set and a TID is free: select the first valid port at or after rr_ptr, cyclically.
  - Pulse req_ready_o for that port in the same cycle (combinational).
  - Capture addr, we, wdata, be, port index and the lowest free TID into the hold register.
  - Go to HOLD.
  - If no TID is free: all req_ready_o=0 and the FSM stays in IDLE.
- HOLD:
  - mem_req_o=1; mem_* outputs driven from the hold register and stable until granted.
  - On mem_gnt_i=1: mark the TID busy, write table[TID]=port, set rr_ptr=port+1 mod NR_PORTS, return to IDLE.
  - No same-cycle re-arbitration; sustained throughput is one request per 2 cycles.
- Latency: requester accept to mem_req_o is 1 cycle.
- Response path:
  - On mem_rvalid_i with a busy TID: rsp_valid_o[table[rtid]]=1 in the same cycle, rsp_rdata_o=mem_rdata_i, TID freed at the clock edge.
  - rsp_rdata_o=0 when no response is valid.
  - A response on a free TID is ignored; with MEM_ARB_ASSERT_EN active it fires an assertion.
  - Writes also return a response (ack); rdata is don't-care.
- Simultaneous grant and response:
  - Free and allocate in the same cycle are both legal.
  - A TID freed this cycle is not visible as free until the next cycle.
- Pool full: no ready is given until a response frees a TID.
- Fairness: each continuously requesting port is served within NR_PORTS grants.
- busy_o = (FSM==HOLD) OR (any TID busy).

Optional Feature:
- Macro DCACHE_ARB_PERF_EN.
- When defined:
  - Adds output stall_cnt_o, NR_PORTS*16 bits.
  - Per-port saturating counter increments each cycle that req_valid_i[p]=1 and req_ready_o[p]=0.
  - Counters are cleared by reset.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package dcache_arb_pkg holds:
  - typedef arb_state_e {IDLE, HOLD};
  - typedef hold_req_t (addr, we, wdata, be, port, tid);
  - function rr_select(valid, ptr) returning index and found flag.
- One sub-module, tid_pool: free bitmap with lowest-free allocate and free-by-ID, plus the port table.

Test Plan:
- Single request: port 1 requests addr 0x8000_0040, read.
  - ready[1] in cycle 0; mem_req_o with tid=0 in cycle 1.
  - mem_rvalid_i with rtid=0 and rdata 0xDEAD_BEEF gives rsp_valid_o=3'b010 with that data.
- Round-robin: ports 0, 1, 2 request continuously, gnt always 1, responses returned immediately.
  - Grant order is 0, 1, 2, 0, 1, 2.
  - Each port gets exactly 2 of 6 grants.
- Pool exhaustion: 4 requests granted, no responses.
  - 5th request sees ready=0 indefinitely.
  - Response on tid 2 makes ready rise the next cycle; the 5th request gets tid 2.
- Out-of-order responses: tids 0 (port 0), 1 (port 2), 2 (port 1) returned in order 2, 0, 1.
  - rsp_valid_o sequence is 010, 001, 100.
- Grant hold and reset: mem_gnt_i held 0 for 5 cycles.
  - mem_addr_o and mem_tid_o stay stable throughout.
  - rst_ni=0 in cycle 3 gives mem_req_o=0 and busy_o=0 next cycle.
  - A stale response afterwards produces no rsp_valid_o.
- With DCACHE_ARB_PERF_EN: port 0 held off 7 cycles by pool exhaustion gives stall_cnt_o[0]=7.
